pattern_scan_arbiter: RTL and testbench
=======================================

// Module: pattern_scan_arbiter
// PURPOSE
//  Shares one serial bit-pattern scanner among NREQ requesters. Round-robin arbiter grants one
//  requester at a time, latches its FRAME_W-bit word, shifts it MSB-first through a PAT_W-bit
//  match window and returns hit flag and match count with requester id. Sequences the
//  serial pattern-detect datapath for multiple sources; pattern is runtime-configurable.
// PARAMETERS
//  NREQ        4        number of requesters (>=2)
//  FRAME_W     16       bits per submitted frame
//  PAT_W       12       pattern length (1..FRAME_W)
//  PAT_DEFAULT 12'hEDB  pattern loaded at reset (1110_1101_1011)
// PORTS
//  clk         in   1                    clock, rising edge
//  rst         in   1                    synchronous, active-high reset
//  req_valid   in   NREQ                 per-requester frame valid
//  req_data    in   NREQ*FRAME_W         frame of requester i at [i*FRAME_W +: FRAME_W]
//  req_ready   out  NREQ                 one-hot accept; transfer when valid&ready
//  cfg_we      in   1                    pattern write strobe
//  cfg_pattern in   PAT_W                new pattern
//  busy        out  1                    high in any state other than IDLE
//  res_valid   out  1                    result valid, held until res_ready
//  res_ready   in   1                    result accept
//  res_id      out  $clog2(NREQ)         requester of this result
//  res_hit     out  1                    res_count != 0
//  res_count   out  $clog2(FRAME_W-PAT_W+2) matches in frame
// BEHAVIOUR
//  - Reset: state IDLE; req_ready=0, busy=0, res_valid=0, res_id=0, res_hit=0, res_count=0;
//    pattern=PAT_DEFAULT; rr pointer = NREQ-1 (requester 0 has first priority). Reset
//    mid-operation aborts the frame; no result is produced for it.
//  - FSM IDLE -> SCAN -> REPORT -> IDLE.
//  - IDLE: if cfg_we, pattern<=cfg_pattern, no grant that cycle (cfg has priority). Else if
//    any req_valid: req_ready (combinational) = one-hot of first valid requester after rr
//    pointer, wrapping. On transfer (cycle T): latch frame and id, rr<=id, clear window,
//    bit counter and match count; go SCAN.
//  - SCAN: cycles T+1..T+FRAME_W, one bit per cycle, MSB first. cand={window[PAT_W-2:0],bit}.
//    Match when bits_seen+1>=PAT_W and cand==pattern; match count increments. After
//    FRAME_W bits go REPORT. cfg_we ignored outside IDLE.
//  - REPORT: res_valid=1 from cycle T+FRAME_W+1 with res_id/res_hit/res_count stable; on
//    res_valid&res_ready return to IDLE (res_valid drops next cycle). No req_ready while busy.
//  - Minimum frame-to-frame spacing FRAME_W+2 cycles with res_ready tied high.
//  - req_valid dropped by a non-granted requester: no effect; grant recomputed each IDLE cycle.
// CONFIGURATION
//  - OVERLAP_SCAN_EN defined: matches may overlap; window/bit counter continue after a hit.
//  - OVERLAP_SCAN_EN undefined: after a hit bits_seen resets to 0; next match needs PAT_W
//    fresh bits (non-overlapping).
// TESTING
//  1. Reset, req0 frame 16'hEDB0 -> req_ready[0] at T, res_valid at T+17, id=0, hit=1, count=1.
//  2. cfg pattern 12'hFFF, req1 frame 16'hFFFF -> count=5 with OVERLAP_SCAN_EN, count=1 without.
//  3. All four req_valid high continuously, frames 0 -> grants/res_id order 0,1,2,3,0; hit=0.
//  4. res_ready low 5 cycles in REPORT -> res_valid and fields held; req_ready stays 0; busy=1.
//  5. cfg_we with 12'h000 during SCAN -> ignored (frame 16'hEDB0 still count=1); same
//     write in IDLE with req_valid high -> no grant that cycle, grant next cycle.
//  6. rst at T+6 of a frame -> all outputs 0 next cycle, pattern=12'hEDB, no result for
//     aborted frame; still-valid req2 with req0 also valid -> req0 granted first.

Source files
------------

// File: rtl/pattern_scan_arbiter.sv
// pattern_scan_arbiter: round-robin arbiter sharing one serial pattern scanner.
// Build option: define OVERLAP_SCAN_EN to count overlapping matches.
module pattern_scan_arbiter #(
    parameter int NREQ    = 4,
    parameter int FRAME_W = 16,
    parameter int PAT_W   = 12,
    parameter logic [PAT_W-1:0] PAT_DEFAULT = 12'hEDB
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [NREQ-1:0]                         req_valid,
    input  logic [NREQ*FRAME_W-1:0]                 req_data,
    output logic [NREQ-1:0]                         req_ready,
    input  logic                                    cfg_we,
    input  logic [PAT_W-1:0]                        cfg_pattern,
    output logic                                    busy,
    output logic                                    res_valid,
    input  logic                                    res_ready,
    output logic [$clog2(NREQ)-1:0]                 res_id,
    output logic                                    res_hit,
    output logic [$clog2(FRAME_W-PAT_W+2)-1:0]      res_count
);

    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(FRAME_W - PAT_W + 2);
    localparam int BW  = $clog2(FRAME_W + 2);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t           state;
    state_t           next;
    logic [IDW-1:0]   rr;
    logic [FRAME_W-1:0] frame;
    logic [PAT_W-1:0] window;
    logic [PAT_W-1:0] pattern;
    logic [PAT_W-1:0] cand;
    logic [BW-1:0]    bit_cnt;
    logic [BW-1:0]    bits_seen;
    logic [IDW-1:0]   grant_id;
    logic             grant_any;
    logic             take;
    logic             match;

    // Round-robin pick: lowest offset after rr wins, so scan offsets high to low.
    always_comb begin
        grant_id  = '0;
        grant_any = 1'b0;
        for (int k = NREQ; k >= 1; k--) begin
            if (req_valid[(int'(rr) + k) % NREQ]) begin
                grant_any = 1'b1;
                grant_id  = IDW'((int'(rr) + k) % NREQ);
            end
        end
    end

    assign take  = (state == IDLE) && !rst && !cfg_we && grant_any;
    assign cand  = PAT_W'({window, frame[FRAME_W-1]});
    assign match = (state == SCAN)
                && (int'(bits_seen) + 1 >= PAT_W)
                && (cand == pattern);
    assign res_hit = (res_count != '0);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next;
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        next      = state;
        req_ready = '0;
        busy      = (state != IDLE);
        res_valid = (state == REPORT);
        unique case (state)
            IDLE: begin
                if (take) begin
                    req_ready = NREQ'(1) << grant_id;
                    next      = SCAN;
                end
            end
            SCAN: begin
                if (bit_cnt == BW'(FRAME_W - 1)) next = REPORT;
            end
            REPORT: begin
                if (res_ready) next = IDLE;
            end
            default: next = IDLE;
        endcase
    end

    // Frame capture, serial scan and result bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            pattern   <= PAT_DEFAULT;
            rr        <= IDW'(NREQ - 1);
            frame     <= '0;
            window    <= '0;
            bit_cnt   <= '0;
            bits_seen <= '0;
            res_id    <= '0;
            res_count <= '0;
        end else if (state == IDLE) begin
            if (cfg_we) begin
                pattern <= cfg_pattern;
            end else if (take) begin
                frame     <= req_data[int'(grant_id)*FRAME_W +: FRAME_W];
                res_id    <= grant_id;
                rr        <= grant_id;
                window    <= '0;
                bit_cnt   <= '0;
                bits_seen <= '0;
                res_count <= '0;
            end
        end else if (state == SCAN) begin
            frame   <= frame << 1;
            window  <= cand;
            bit_cnt <= bit_cnt + BW'(1);
            if (match) res_count <= res_count + CW'(1);
`ifdef OVERLAP_SCAN_EN
            bits_seen <= bits_seen + BW'(1);
`else
            if (match) bits_seen <= '0;
            else       bits_seen <= bits_seen + BW'(1);
`endif
        end
    end

endmodule

// File: tb/tb_pattern_scan_arbiter.sv
// tb_pattern_scan_arbiter: scoreboard bench with a transaction-level model.
// Honors OVERLAP_SCAN_EN in the reference match count.
module tb_pattern_scan_arbiter;

    localparam int NREQ    = 4;
    localparam int FRAME_W = 16;
    localparam int PAT_W   = 12;
    localparam logic [PAT_W-1:0] PAT_DEFAULT = 12'hEDB;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NREQ-1:0]          req_valid;
    logic [NREQ*FRAME_W-1:0]  req_data;
    logic [NREQ-1:0]          req_ready;
    logic                     cfg_we;
    logic [PAT_W-1:0]         cfg_pattern;
    logic                     busy;
    logic                     res_valid;
    logic                     res_ready;
    logic [1:0]               res_id;
    logic                     res_hit;
    logic [2:0]               res_count;

    pattern_scan_arbiter dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
        .res_id(res_id), .res_hit(res_hit), .res_count(res_count)
    );

    always #5 clk = ~clk;

    typedef struct { int id; int count; } exp_t;

    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb[$];
    int   grant_log[$];
    int   results_seen = 0;
    int   cyc = 0;
    bit   mon_en = 0;
    bit   just_reset = 0;
    bit   pending = 0;
    int   report_cyc = 0;
    int   m_rr = NREQ - 1;
    logic [PAT_W-1:0] m_pat = PAT_DEFAULT;
    logic [NREQ-1:0]  exp_ready;
    int   gid;
    logic [FRAME_W-1:0] cap;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Count pattern occurrences in the MSB-first bit stream of a frame.
    function automatic int model_count(logic [FRAME_W-1:0] f,
                                       logic [PAT_W-1:0] p);
        int c;
        int free_from;
        logic [PAT_W-1:0] w;
        c = 0;
        free_from = 0;
        for (int e = PAT_W - 1; e < FRAME_W; e++) begin
            w = f[FRAME_W-1-e +: PAT_W];
            if (w == p && (e - PAT_W + 1) >= free_from) begin
                c++;
`ifndef OVERLAP_SCAN_EN
                free_from = e + 1;
`endif
            end
        end
        return c;
    endfunction

    // Monitor: compare every cycle against the model, then advance it.
    always @(negedge clk) begin
        cyc++;
        if (mon_en) begin
            exp_ready = '0;
            gid = -1;
            if (!pending && !rst && !cfg_we)
                for (int k = 1; k <= NREQ; k++)
                    if (gid < 0 && req_valid[(m_rr + k) % NREQ])
                        gid = (m_rr + k) % NREQ;
            if (gid >= 0) exp_ready[gid] = 1'b1;
            check("req_ready", req_ready, exp_ready);
            check("busy", busy, pending);
            check("res_valid", res_valid, pending && cyc >= report_cyc);
            if (just_reset) begin
                check("rst_res_id", res_id, 0);
                check("rst_res_hit", res_hit, 0);
                check("rst_res_count", res_count, 0);
                just_reset = 0;
            end
            if (pending && cyc >= report_cyc) begin
                if (sb.size() == 0) begin
                    check("sb_empty", 1, 0);
                end else begin
                    check("res_id", res_id, sb[0].id);
                    check("res_count", res_count, sb[0].count);
                    check("res_hit", res_hit, sb[0].count != 0);
                end
            end
            if (rst) begin
                pending = 0;
                m_rr = NREQ - 1;
                m_pat = PAT_DEFAULT;
                sb.delete();
                just_reset = 1;
            end else if (!pending) begin
                if (cfg_we) begin
                    m_pat = cfg_pattern;
                end else if (gid >= 0) begin
                    cap = req_data[gid*FRAME_W +: FRAME_W];
                    sb.push_back('{gid, model_count(cap, m_pat)});
                    grant_log.push_back(gid);
                    m_rr = gid;
                    pending = 1;
                    report_cyc = cyc + FRAME_W + 1;
                end
            end else if (cyc >= report_cyc && res_ready) begin
                void'(sb.pop_front());
                results_seen++;
                pending = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(int id, logic [FRAME_W-1:0] d);
        int n;
        n = 0;
        req_data[id*FRAME_W +: FRAME_W] = d;
        req_valid[id] = 1'b1;
        #1;
        while (!req_ready[id] && n < 300) begin
            step();
            n++;
        end
        if (n >= 300) check("grant_timeout", 0, 1);
        step();
        req_valid[id] = 1'b0;
    endtask

    task automatic wait_results(int target);
        int n;
        n = 0;
        while (results_seen < target && n < 600) begin
            step();
            n++;
        end
        if (n >= 600) check("result_timeout", results_seen, target);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (pending && n < 600) begin
            step();
            n++;
        end
        if (n >= 600) check("idle_timeout", 0, 1);
        step();
    endtask

    task automatic cfg(logic [PAT_W-1:0] p);
        cfg_we = 1'b1;
        cfg_pattern = p;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    function automatic logic [FRAME_W-1:0] pick_frame();
        case ($urandom % 6)
            0: return 16'hFFFF;
            1: return 16'hAAAA;
            2: return 16'hEDB0;
            3: return 16'h0000;
            4: return 16'h0EDB;
            default: return 16'($urandom);
        endcase
    endfunction

    function automatic logic [PAT_W-1:0] pick_pat();
        case ($urandom % 5)
            0: return 12'hEDB;
            1: return 12'hFFF;
            2: return 12'hAAA;
            3: return 12'h000;
            default: return 12'h555;
        endcase
    endfunction

    int base;
    int exp_order[5] = '{0, 1, 2, 3, 0};

    initial begin
        rst = 1'b1;
        req_valid = '0;
        req_data = '0;
        cfg_we = 1'b0;
        cfg_pattern = '0;
        res_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        just_reset = 1;
        mon_en = 1;
        step();

        // Basic frame from requester 0.
        send(0, 16'hEDB0);
        wait_results(1);
        wait_idle();

        // All-ones pattern on an all-ones frame.
        cfg(12'hFFF);
        send(1, 16'hFFFF);
        wait_results(2);
        wait_idle();
        cfg(PAT_DEFAULT);

        // Fairness with every requester valid, after a fresh reset.
        pulse_reset();
        grant_log.delete();
        base = results_seen;
        req_data = '0;
        req_valid = '1;
        wait_results(base + 5);
        req_valid = '0;
        wait_idle();
        for (int i = 0; i < 5; i++) begin
            if (i < grant_log.size()) check("rr_order", grant_log[i], exp_order[i]);
            else check("rr_order_len", grant_log.size(), 5);
        end

        // Back-pressure in REPORT while another requester waits.
        res_ready = 1'b0;
        send(2, 16'hEDB0);
        base = 0;
        while (!res_valid && base < 40) begin step(); base++; end
        req_data[3*FRAME_W +: FRAME_W] = 16'hFFFF;
        req_valid[3] = 1'b1;
        repeat (5) step();
        req_valid[3] = 1'b0;
        res_ready = 1'b1;
        wait_idle();

        // Config writes while scanning are ignored.
        send(0, 16'hEDB0);
        cfg_we = 1'b1;
        cfg_pattern = 12'h000;
        repeat (3) step();
        cfg_we = 1'b0;
        wait_idle();
        // Config write in IDLE wins over a pending request for one cycle.
        req_data[1*FRAME_W +: FRAME_W] = 16'h0000;
        req_valid[1] = 1'b1;
        cfg_we = 1'b1;
        cfg_pattern = 12'h000;
        step();
        cfg_we = 1'b0;
        send(1, 16'h0000);
        wait_idle();
        cfg(PAT_DEFAULT);

        // Reset in the middle of a frame.
        send(0, 16'hEDB0);
        repeat (5) step();
        req_data[0 +: FRAME_W] = 16'hEDB0;
        req_data[2*FRAME_W +: FRAME_W] = 16'hFFFF;
        req_valid = 4'b0101;
        pulse_reset();
        #1;
        check("post_rst_grant", req_ready, 4'b0001);
        step();
        req_valid[0] = 1'b0;
        send(2, 16'hFFFF);
        wait_idle();

        // Randomized traffic.
        for (int c = 0; c < 800; c++) begin
            req_valid = NREQ'($urandom);
            for (int i = 0; i < NREQ; i++)
                req_data[i*FRAME_W +: FRAME_W] = pick_frame();
            res_ready = ($urandom % 4) != 0;
            cfg_we = ($urandom % 20) == 0;
            cfg_pattern = pick_pat();
            rst = ($urandom % 300) == 0;
            step();
        end
        req_valid = '0;
        cfg_we = 1'b0;
        rst = 1'b0;
        res_ready = 1'b1;
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

endmodule
